// File: rtl/uart_rx_at_parser.sv
// 8N1 UART receiver for the ESP8266 link with an "OK\r\n" / "ERROR\r\n" response matcher.
// receiver_OK / receiver_ERR are sticky until uart_tx re-arms them with a receive_ok_en rising edge.
module uart_rx_at_parser #(
  parameter int CLK       = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DIV_NUM   = CLK / BAUD_RATE,
  parameter int HALF_DIV  = DIV_NUM / 2
) (
  input  logic       iCLK,
  input  logic       RST_n,
  input  logic       rx,
  input  logic       receive_ok_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       receiver_OK,
  output logic       receiver_ERR
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic        rx_m_q, rx_s_q, rx_d_q, en_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d, rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
  logic [1:0]  ok_idx_q, ok_idx_d;
  logic [2:0]  err_idx_q, err_idx_d;
  logic        ok_flag_q, ok_flag_d, err_flag_q, err_flag_d;
  logic        fall, rearm, ok_set, err_set;

  function automatic logic [7:0] ok_chr(input logic [1:0] idx);
    case (idx)
      2'd0:    ok_chr = 8'h4F;
      2'd1:    ok_chr = 8'h4B;
      2'd2:    ok_chr = 8'h0D;
      default: ok_chr = 8'h0A;
    endcase
  endfunction

  function automatic logic [7:0] err_chr(input logic [2:0] idx);
    case (idx)
      3'd0:    err_chr = 8'h45;
      3'd1:    err_chr = 8'h52;
      3'd2:    err_chr = 8'h52;
      3'd3:    err_chr = 8'h4F;
      3'd4:    err_chr = 8'h52;
      3'd5:    err_chr = 8'h0D;
      default: err_chr = 8'h0A;
    endcase
  endfunction

  always_ff @(posedge iCLK or negedge RST_n) begin
    if (!RST_n) begin
      rx_m_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_d_q      <= 1'b1;
      en_q        <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      ok_idx_q    <= '0;
      err_idx_q   <= '0;
      ok_flag_q   <= 1'b0;
      err_flag_q  <= 1'b0;
    end else begin
      rx_m_q      <= rx;
      rx_s_q      <= rx_m_q;
      rx_d_q      <= rx_s_q;
      en_q        <= receive_ok_en;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      ok_idx_q    <= ok_idx_d;
      err_idx_q   <= err_idx_d;
      ok_flag_q   <= ok_flag_d;
      err_flag_q  <= err_flag_d;
    end
  end

  assign fall = rx_d_q & ~rx_s_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (cnt_q == 16'(HALF_DIV - 1)) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == 16'(DIV_NUM - 1)) begin
          cnt_d              = '0;
          shift_d[bit_cnt_q] = rx_s_q;
          if (bit_cnt_q == 3'd7) state_d = STOP;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      default: begin
        if (cnt_q == 16'(DIV_NUM - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
    endcase
  end

  // Matcher consumes the registered byte, so flags land one cycle after rx_valid.
  always_comb begin
    ok_idx_d  = ok_idx_q;
    err_idx_d = err_idx_q;
    ok_set    = 1'b0;
    err_set   = 1'b0;
    if (frame_err_q) begin
      ok_idx_d  = '0;
      err_idx_d = '0;
    end else if (rx_valid_q) begin
      if (rx_data_q == ok_chr(ok_idx_q)) begin
        if (ok_idx_q == 2'd3) begin
          ok_idx_d = '0;
          ok_set   = 1'b1;
        end else begin
          ok_idx_d = ok_idx_q + 2'd1;
        end
      end else begin
        ok_idx_d = (rx_data_q == 8'h4F) ? 2'd1 : 2'd0;
      end
      if (rx_data_q == err_chr(err_idx_q)) begin
        if (err_idx_q == 3'd6) begin
          err_idx_d = '0;
          err_set   = 1'b1;
        end else begin
          err_idx_d = err_idx_q + 3'd1;
        end
      end else begin
        err_idx_d = (rx_data_q == 8'h45) ? 3'd1 : 3'd0;
      end
    end
  end

  assign rearm      = receive_ok_en & ~en_q;
  assign ok_flag_d  = ok_set  | (ok_flag_q  & ~rearm);
  assign err_flag_d = err_set | (err_flag_q & ~rearm);

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign frame_err    = frame_err_q;
  assign receiver_OK  = ok_flag_q;
  assign receiver_ERR = err_flag_q;

endmodule

// File: tb/tb_uart_rx_at_parser.sv
// Directed bench for uart_rx_at_parser: expected bytes queued when sent, checked when rx_valid fires.
// Runs at 100 clocks per bit to keep the run short; glitch length is scaled accordingly.
module tb_uart_rx_at_parser;

  localparam int CLKF = 50_000_000;
  localparam int BAUD = 500_000;
  localparam int BIT  = CLKF / BAUD;

  logic       iCLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       rx = 1'b1;
  logic       receive_ok_en = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, receiver_OK, receiver_ERR;

  int         n_assert = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  int         exp_ferr = 0;
  int         got_ferr = 0;
  int         cyc = 0;
  int         last_valid_cyc = -10;
  int         ok_rise_cyc = -1;
  logic       ok_prev = 1'b0;

  uart_rx_at_parser #(.CLK(CLKF), .BAUD_RATE(BAUD)) dut (
    .iCLK(iCLK), .RST_n(RST_n), .rx(rx), .receive_ok_en(receive_ok_en),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .receiver_OK(receiver_OK), .receiver_ERR(receiver_ERR)
  );

  always #10 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge iCLK) begin
    cyc++;
    if (rx_valid) begin
      last_valid_cyc = cyc;
      check("rx_valid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
    end
    if (frame_err) got_ferr++;
    if (receiver_OK && !ok_prev) ok_rise_cyc = cyc;
    ok_prev = receiver_OK;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    if (stop) exp_q.push_back(b);
    else      exp_ferr++;
    rx = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(BIT);
    end
    rx = stop;
    tick(BIT);
    if (!stop) begin
      rx = 1'b1;
      tick(BIT);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic drained(input string tag);
    check({tag, "_pending_bytes"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_frame_err_count"}, 32'(got_ferr), 32'(exp_ferr));
  endtask

  initial begin
    tick(3);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_ok", 32'(receiver_OK), 32'd0);
    check("reset_err", 32'(receiver_ERR), 32'd0);
    RST_n = 1'b1;
    tick(5);

    // 1: single byte
    send_byte(8'hA5, 1'b1);
    tick(BIT);
    drained("t1");
    check("t1_rx_data", 32'(rx_data), 32'hA5);

    // 2: command echo then OK
    send_str("AT\r\nOK\r\n");
    tick(5);
    drained("t2");
    check("t2_ok", 32'(receiver_OK), 32'd1);
    check("t2_err", 32'(receiver_ERR), 32'd0);
    check("t2_ok_latency", 32'(ok_rise_cyc), 32'(last_valid_cyc + 1));

    // 3: re-arm on edge, held enable does not block a new set
    receive_ok_en = 1'b1;
    @(negedge iCLK);
    check("t3_ok_before_edge", 32'(receiver_OK), 32'd1);
    @(negedge iCLK);
    check("t3_ok_cleared", 32'(receiver_OK), 32'd0);
    tick(1000);
    check("t3_ok_held", 32'(receiver_OK), 32'd0);
    send_str("OOK\r\n");
    tick(5);
    drained("t3");
    check("t3_ok_fallback", 32'(receiver_OK), 32'd1);
    receive_ok_en = 1'b0;
    tick(5);
    check("t3_ok_sticky", 32'(receiver_OK), 32'd1);

    // 4: ERROR, then OK\r broken by a framing error
    receive_ok_en = 1'b1;
    tick(3);
    receive_ok_en = 1'b0;
    check("t4_ok_rearmed", 32'(receiver_OK), 32'd0);
    send_str("ERROR\r\n");
    tick(5);
    check("t4_err", 32'(receiver_ERR), 32'd1);
    check("t4_ok", 32'(receiver_OK), 32'd0);
    send_str("OK\r");
    send_byte(8'h0A, 1'b0);
    send_byte(8'h0A, 1'b1);
    tick(5);
    drained("t4");
    check("t4_ok_after_ferr", 32'(receiver_OK), 32'd0);
    check("t4_err_sticky", 32'(receiver_ERR), 32'd1);

    // 5: short glitch on idle line
    rx = 1'b0;
    tick(20);
    rx = 1'b1;
    tick(3 * BIT);
    drained("t5_glitch");
    send_byte(8'h4F, 1'b1);
    tick(5);
    drained("t5");
    check("t5_rx_data", 32'(rx_data), 32'h4F);

    // 6: reset in the middle of a byte
    rx = 1'b0;
    tick(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      tick(BIT);
    end
    RST_n = 1'b0;
    tick(2);
    check("t6_rst_rx_data", 32'(rx_data), 32'h00);
    check("t6_rst_err", 32'(receiver_ERR), 32'd0);
    rx = 1'b1;
    tick(3);
    RST_n = 1'b1;
    tick(2 * BIT);
    drained("t6_abort");
    send_byte(8'h0A, 1'b1);
    tick(5);
    drained("t6");
    check("t6_rx_data", 32'(rx_data), 32'h0A);
    check("t6_ok", 32'(receiver_OK), 32'd0);
    check("t6_err", 32'(receiver_ERR), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_at_parser.md
Name: uart_rx_at_parser

Overview:
- UART receiver plus AT-response parser for the ESP8266 link on the UART_Client board.
- Sits directly downstream of the Wi-Fi module's TX pin and upstream of uart_tx.
- Deserialises 8N1 bytes at 115200 baud and scans the stream for "OK\r\n" and "ERROR\r\n".
- Drives receiver_OK, the handshake uart_tx waits on before sending its next AT command, and re-arms it each time uart_tx raises receive_ok_en.

Parameters:
CLK, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line baud rate
DIV_NUM, CLK/BAUD_RATE (434), clock cycles per bit
HALF_DIV, DIV_NUM/2 (217), cycles from start-bit edge to the start-bit mid-point

Ports:
iCLK  input  1  system clock, rising edge
RST_n  input  1  asynchronous active-low reset
rx  input  1  serial line from ESP8266; idles high; asynchronous to iCLK
receive_ok_en  input  1  from uart_tx; high while uart_tx waits in STOP after a 0x0A byte
rx_data  output  8  last correctly framed byte
rx_valid  output  1  one-cycle pulse when rx_data is updated
frame_err  output  1  one-cycle pulse when the stop bit is sampled low
receiver_OK  output  1  sticky flag: "OK\r\n" received since last re-arm
receiver_ERR  output  1  sticky flag: "ERROR\r\n" received since last re-arm

Behaviour:
- Interface: one clock, iCLK. Reset RST_n is asynchronous and active-low.
- Reset values:
  - rx_data = 0x00.
  - rx_valid, frame_err, receiver_OK and receiver_ERR = 0.
  - Synchroniser flops = 1. FSM state = IDLE. All counters and match indices = 0.
- Synchroniser:
  - rx passes through two flops, giving rx_s.
  - A third flop holds rx_d, the previous value of rx_s.
  - Falling edge = rx_d==1 && rx_s==0.
- Receive FSM states: IDLE, START, DATA, STOP. There is one baud counter, cleared on every state change.
- IDLE: on a falling edge go to START.
- START:
  - At count HALF_DIV-1, sample rx_s.
  - If rx_s is 0, go to DATA. If rx_s is 1, treat it as a glitch and go back to IDLE with no output.
- DATA:
  - At count DIV_NUM-1, sample rx_s into shift bit bit_cnt. Data is LSB first.
  - bit_cnt runs 0..7. After bit 7 is sampled, go to STOP.
- STOP:
  - At count DIV_NUM-1, sample rx_s.
  - If rx_s is 1: load rx_data with the shift register and pulse rx_valid for exactly the next cycle.
  - If rx_s is 0: pulse frame_err for one cycle and leave rx_data unchanged.
  - In both cases return to IDLE.
  - A new start bit is accepted only after the line has been seen high, because IDLE requires a falling edge.
- Latency: rx_valid rises 1 cycle after the stop-bit sample, about 9.5 bit times (~4123 cycles) after the start edge.
- Matcher:
  - Only bytes accepted with rx_valid advance the matcher. A frame_err resets both match indices to 0.
  - OK index 0..3 tracks the sequence 0x4F 0x4B 0x0D 0x0A.
  - ERROR index 0..6 tracks the sequence 0x45 0x52 0x52 0x4F 0x52 0x0D 0x0A.
  - A byte that matches the expected character increments its index.
  - On a mismatch, the index becomes 1 if the byte equals the first character of that sequence, else 0.
  - Completing a sequence sets the matching sticky flag and resets that index to 0. Both sequences are tracked independently.
- Re-arm:
  - A rising edge of receive_ok_en (registered copy 0, current 1) clears receiver_OK and receiver_ERR.
  - If a set and a clear occur in the same cycle, set wins.
- receive_ok_en being held high does not repeatedly clear the flags; only the edge clears them.
- Reset asserted mid-frame: immediate return to reset values. The partial byte is discarded with no pulse.
- rx held low permanently: one frame_err, then the FSM stays in IDLE until the line goes high and then falls.

Test Plan:
1. Send 0xA5 framed 8N1 at 434 cycles/bit -> one rx_valid pulse, rx_data=0xA5, frame_err stays 0, FSM back in IDLE.
2. Send "AT\r\nOK\r\n" -> receiver_OK rises 1 cycle after the final 0x0A rx_valid and stays high; receiver_ERR stays 0.
3. With receiver_OK=1, pulse receive_ok_en 0->1 and hold it high 1000 cycles -> receiver_OK clears on the edge cycle. Then send "OOK\r\n" -> receiver_OK=1 again, confirming the mismatch fallback to index 1.
4. Send "ERROR\r\n" -> receiver_ERR=1, receiver_OK=0. Then send "OK\r" followed by a byte with the stop bit low -> frame_err pulse, OK index resets, receiver_OK stays 0.
5. Drive a 100-cycle low glitch on an idle line -> no rx_valid and no frame_err; a following valid 0x4F is received correctly.
6. Assert RST_n low at bit 4 of a byte, then release it and send 0x0A -> no output from the aborted byte; the next byte gives rx_data=0x0A and all flags stay 0.
